// File: rtl/edc_pkg.sv
// Shared widths, command encodings and FSM states for the EDC fault-injection initiator.
package edc_pkg;

    localparam int unsigned EDC_DATA_W  = 32;
    localparam int unsigned EDC_PAR_W   = 7;
    localparam int unsigned EDC_ADDR_W  = 9;
    localparam int unsigned USER_ADDR_W = 13;
    localparam int unsigned LAT_W       = 2;

    typedef enum logic [1:0] {
        OP_FLIP  = 2'b00,
        OP_PROBE = 2'b01,
        OP_LOAD  = 2'b10,
        OP_RSVD  = 2'b11
    } edc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } edc_state_e;

    typedef struct packed {
        edc_op_e                 op;
        logic [EDC_ADDR_W-1:0]   addr;
        logic [EDC_DATA_W-1:0]   dmask;
        logic [EDC_PAR_W-1:0]    pmask;
    } edc_cmd_t;

    // {data strobe, parity strobe}: FLIP writes only non-zero masks, LOAD always writes both.
    function automatic logic [1:0] edc_strobes(input edc_op_e op, input logic dm_nz, input logic pm_nz);
        logic [1:0] s;
        s = 2'b00;
        if (op == OP_FLIP) begin
            s = {dm_nz, pm_nz};
        end else if (op == OP_LOAD) begin
            s = 2'b11;
        end
        return s;
    endfunction

endpackage

// File: rtl/edc_fault_injector.sv
// Read-modify-write initiator for one data word plus parity on the core's EDC/debug ports.
// One command in flight: IDLE -> READ (RD_LAT cycles) -> WRITE (1 cycle) -> RESP -> IDLE.
module edc_fault_injector
    import edc_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [EDC_ADDR_W-1:0]   cmd_addr,
    input  logic [EDC_DATA_W-1:0]   cmd_dmask,
    input  logic [EDC_PAR_W-1:0]    cmd_pmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [EDC_DATA_W-1:0]   rsp_data,
    output logic [EDC_PAR_W-1:0]    rsp_par,
    output logic                    rsp_wrote,
    output logic [CNT_W-1:0]        inj_count,
    output logic [USER_ADDR_W-1:0]  user_addr,
    output logic                    user_we,
    input  logic [EDC_DATA_W-1:0]   user_dout,
    output logic [EDC_ADDR_W-1:0]   error_addr,
    output logic                    error_dwe,
    output logic                    error_pwe,
    output logic [EDC_DATA_W-1:0]   error_din,
    output logic [EDC_PAR_W-1:0]    error_pin,
    input  logic [EDC_PAR_W-1:0]    parity_dout
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    edc_state_e                 r_state,     w_state_nxt;
    edc_cmd_t                   r_cmd,       w_cmd_nxt;
    logic [LAT_W-1:0]           r_lat,       w_lat_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic [EDC_DATA_W-1:0]      r_rsp_data,  w_rsp_data_nxt;
    logic [EDC_PAR_W-1:0]       r_rsp_par,   w_rsp_par_nxt;
    logic                       r_rsp_wrote, w_rsp_wrote_nxt;
    logic [CNT_W-1:0]           r_inj_count, w_inj_count_nxt;
    logic                       r_dwe,       w_dwe_nxt;
    logic                       r_pwe,       w_pwe_nxt;
    logic [EDC_DATA_W-1:0]      r_din,       w_din_nxt;
    logic [EDC_PAR_W-1:0]       r_pin,       w_pin_nxt;
    logic [1:0]                 w_strb;

    assign w_strb = edc_strobes(r_cmd.op, |r_cmd.dmask, |r_cmd.pmask);

    // State register; async reset also drops any strobe in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_lat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_par   <= '0;
            r_rsp_wrote <= 1'b0;
            r_inj_count <= '0;
            r_dwe       <= 1'b0;
            r_pwe       <= 1'b0;
            r_din       <= '0;
            r_pin       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_lat       <= w_lat_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_par   <= w_rsp_par_nxt;
            r_rsp_wrote <= w_rsp_wrote_nxt;
            r_inj_count <= w_inj_count_nxt;
            r_dwe       <= w_dwe_nxt;
            r_pwe       <= w_pwe_nxt;
            r_din       <= w_din_nxt;
            r_pin       <= w_pin_nxt;
        end
    end

    // Next-state and next-output logic; write-path signals default low so they live one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_lat_nxt       = r_lat;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_par_nxt   = r_rsp_par;
        w_rsp_wrote_nxt = r_rsp_wrote;
        w_inj_count_nxt = r_inj_count;
        w_dwe_nxt       = 1'b0;
        w_pwe_nxt       = 1'b0;
        w_din_nxt       = '0;
        w_pin_nxt       = '0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_nxt.op    = edc_op_e'(cmd_op);
                    w_cmd_nxt.addr  = cmd_addr;
                    w_cmd_nxt.dmask = cmd_dmask;
                    w_cmd_nxt.pmask = cmd_pmask;
                    w_lat_nxt       = '0;
                    w_state_nxt     = ST_READ;
                end
            end
            ST_READ: begin
                if (r_lat == LAT_LAST) begin
                    w_rsp_data_nxt = user_dout;
                    w_rsp_par_nxt  = parity_dout;
                    w_dwe_nxt      = w_strb[1];
                    w_pwe_nxt      = w_strb[0];
                    if (r_cmd.op == OP_LOAD) begin
                        w_din_nxt = r_cmd.dmask;
                        w_pin_nxt = r_cmd.pmask;
                    end else if (r_cmd.op == OP_FLIP) begin
                        w_din_nxt = user_dout ^ r_cmd.dmask;
                        w_pin_nxt = parity_dout ^ r_cmd.pmask;
                    end
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_lat_nxt = r_lat + LAT_W'(1);
                end
            end
            ST_WRITE: begin
                w_rsp_wrote_nxt = r_dwe | r_pwe;
                if ((r_dwe | r_pwe) && (r_inj_count != '1)) begin
                    w_inj_count_nxt = r_inj_count + CNT_W'(1);
                end
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_nxt       = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The registered command is cleared on return to IDLE, so addresses read 0 there.
    assign cmd_ready  = (r_state == ST_IDLE) & ~rst;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_par    = r_rsp_par;
    assign rsp_wrote  = r_rsp_wrote;
    assign inj_count  = r_inj_count;
    assign user_addr  = USER_ADDR_W'(r_cmd.addr);
    assign user_we    = 1'b0;
    assign error_addr = r_cmd.addr;
    assign error_dwe  = r_dwe;
    assign error_pwe  = r_pwe;
    assign error_din  = r_din;
    assign error_pin  = r_pin;

endmodule
